uart_transmitter: RTL and testbench
===================================

Name: uart_transmitter

Overview:
- Byte-oriented UART transmitter: the serial output direction complementing the SoC's UART receive path.
- Accepts bytes over a valid/ready handshake into a small synchronous FIFO.
- Serialises each byte as 8N1, LSB first, at a fixed baud derived from parameters.
- Used inside the SoC on the UART output pin, and in benches as the host-side driver of the SoC's serial input.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz (10 ns period).
- BAUD_RATE, 115200, serial bit rate.
- FIFO_DEPTH, 16, transmit FIFO entries; power of two, >= 2.
- CLKS_PER_BIT (localparam), CLK_FREQ/BAUD_RATE with integer truncation; must be >= 2 (elaboration assertion).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; synchronous, active-high.
- tx_data  input  8  byte to send.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  FIFO can accept; a transfer occurs on a rising edge with tx_valid && tx_ready.
- tx  output  1  serial line; idles high.
- busy  output  1  frame in progress or FIFO non-empty.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values, held while rst=1: tx=1, tx_ready=0, busy=0, fifo_count=0, FSM=IDLE. FIFO is emptied.
- tx_ready goes high on the first edge after rst deasserts.
- Reset mid-frame aborts the frame immediately: tx=1 on the next edge and queued bytes are discarded.
- Handshake:
  - tx_ready = !full, registered.
  - tx_data must be stable only in the transfer cycle.
  - A push while full is impossible by construction; tx_valid is ignored when tx_ready=0.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO non-empty, pop into shift register, go to START. tx=1.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles, then shift right. After bit index 7, go to STOP. The bit index is a 3-bit counter and wraps.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
    - At the end of STOP, if FIFO non-empty: pop and go directly to START, so back-to-back frames have no extra idle.
    - Otherwise go to IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1. It resets to 0 on every state entry. Each bit lasts exactly CLKS_PER_BIT clocks, so a frame is exactly 10*CLKS_PER_BIT clocks.
- tx is registered, with no combinational path from inputs.
- Latency: for a byte accepted at edge N into an empty FIFO with FSM in IDLE, tx falls at edge N+2. Edge N+1 performs the pop; the START state drives tx=0 from edge N+2.
- Simultaneous push and pop in the same cycle are allowed. Occupancy is unchanged and data ordering is preserved.
- busy=1 whenever FSM != IDLE or fifo_count != 0. busy goes high at the edge after the first accepted transfer.
- fifo_count excludes the byte held in the shift register.
- Arithmetic: FIFO pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally. Count is one bit wider so it can represent full.

Decomposition:
- Package uart_pkg:
  - typedef enum for the tx FSM (IDLE, START, DATA, STOP);
  - localparam UART_DATA_BITS=8;
  - function clks_per_bit(clk_freq, baud).
- The package is shared with the existing receiver.
- One sub-module: sync_fifo (parameterised WIDTH, DEPTH; push/pop/full/empty/count), reusable elsewhere in the SoC.

Test Plan (CLK_FREQ=1000, BAUD_RATE=100 → CLKS_PER_BIT=10):
- Reset:
  - rst held 10 cycles → tx=1, tx_ready=0, busy=0, fifo_count=0 throughout.
  - tx_ready=1 one edge after release.
- Single byte 0x55 pushed at edge N:
  - tx falls at N+2.
  - Line sequence: 0 then 1,0,1,0,1,0,1,0, each exactly 10 cycles.
  - Stop bit high 10 cycles.
  - busy drops at N+102.
- Back-to-back 0xA3 then 0x0F in consecutive cycles:
  - Two frames, 200 cycles total.
  - Second start bit begins the cycle after the first stop bit ends.
  - Decoded bytes are 0xA3, 0x0F in order.
- Overflow: push 18 bytes on consecutive cycles.
  - Exactly 17 are accepted (16 in the FIFO, 1 in the shifter), and tx_ready is low after the 17th.
  - tx_ready reasserts one cycle after the second pop (about 100 cycles later).
  - All 17 bytes are transmitted in order.
- Reset mid-frame: assert rst during the DATA bit 3 of 0xFF with 3 bytes queued.
  - tx=1 on the next edge, fifo_count=0.
  - No further frames after release.
- Loopback with the existing receiver (rx input tied to tx): 256 bytes 0x00..0xFF → all received intact, no framing errors.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and the existing receiver.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO; o_data shows the head entry whenever non-empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sync_fifo DEPTH must be a power of two and >= 2");
    end

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_full;
    logic             w_push_ok;
    logic             w_pop_ok;
    logic [AW:0]      w_count_next;

    assign w_push_ok = i_push && !r_full;
    assign w_pop_ok  = i_pop && (r_count != '0);

    always_comb begin
        w_count_next = r_count;
        if (w_push_ok && !w_pop_ok) begin
            w_count_next = r_count + 1'b1;
        end else if (w_pop_ok && !w_push_ok) begin
            w_count_next = r_count - 1'b1;
        end
    end

    // Full is derived from the next count so it is already valid in the cycle after the filling push.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_next;
            r_full  <= (w_count_next == FULL_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter, LSB first, fed from a transmit FIFO over a valid/ready handshake.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [UART_DATA_BITS-1:0]     tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(UART_DATA_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("CLKS_PER_BIT must be >= 2");
    end

    tx_state_t                  r_state;
    logic [BW-1:0]              r_baud;
    logic [2:0]                 r_bit_idx;
    logic [UART_DATA_BITS-1:0]  r_shift;
    logic                       r_tx;
    logic                       r_busy;
    logic                       r_ready_en;

    logic [UART_DATA_BITS-1:0]  w_fifo_data;
    logic                       w_full;
    logic                       w_empty;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_bit_done;

    // Transfer happens on a rising edge where tx_valid && tx_ready; tx_data need only be stable then.
    assign w_push     = tx_valid && tx_ready;
    assign w_bit_done = (r_baud == BAUD_LAST);
    assign w_pop      = !w_empty && ((r_state == IDLE) || ((r_state == STOP) && w_bit_done));

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (tx_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_baud <= '0;
                    if (!w_empty) begin
                        r_shift <= w_fifo_data;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_bit_done) begin
                        r_baud    <= '0;
                        r_bit_idx <= '0;
                        r_state   <= DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                DATA: begin
                    if (w_bit_done) begin
                        r_baud    <= '0;
                        r_shift   <= r_shift >> 1;
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == LAST_BIT) r_state <= STOP;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                STOP: begin
                    // Chaining straight into START keeps queued frames back-to-back.
                    if (w_bit_done) begin
                        r_baud <= '0;
                        if (!w_empty) begin
                            r_shift <= w_fifo_data;
                            r_state <= START;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Line and status are registered from the current state, one cycle behind it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_ready_en <= 1'b0;
        end else begin
            case (r_state)
                START:   r_tx <= 1'b0;
                DATA:    r_tx <= r_shift[0];
                default: r_tx <= 1'b1;
            endcase
            r_busy     <= (r_state != IDLE) || !w_empty;
            r_ready_en <= 1'b1;
        end
    end

    assign tx_ready = r_ready_en && !w_full;
    assign tx       = r_tx;
    assign busy     = r_busy;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter at 10 clocks per bit, with a line decoder and expected-byte queue.
module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       busy;
  logic [4:0] fifo_count;

  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  uart_transmitter #(
    .CLK_FREQ   (1000),
    .BAUD_RATE  (100),
    .FIFO_DEPTH (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line level at position pos (0..99) within an 8N1 frame of byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int pos);
    int slot;
    slot = pos / 10;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return b[slot-1];
  endfunction

  // Returns just after the accepting edge (#1 past it).
  task automatic push_byte(input logic [7:0] d);
    int guard;
    guard = 0;
    tx_data = d;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && guard < 3000) begin
      tick();
      guard++;
    end
    check("push_ready", {31'd0, tx_ready}, 32'd1);
    tick();
    tx_valid = 1'b0;
    exp_q.push_back(d);
  endtask

  // Samples the line mid-bit on falling clock edges.
  task automatic recv_byte(output logic [7:0] b, output logic ok);
    int guard;
    guard = 0;
    ok = 1'b1;
    b = 8'h00;
    @(negedge clk);
    while (tx !== 1'b0 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (tx !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    repeat (4) @(negedge clk);
    if (tx !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (10) @(negedge clk);
      b[i] = tx;
    end
    repeat (10) @(negedge clk);
    if (tx !== 1'b1) ok = 1'b0;
  endtask

  task automatic recv_and_score(input string tag, input int n);
    logic [7:0] b;
    logic ok;
    logic [31:0] exp;
    for (int i = 0; i < n; i++) begin
      recv_byte(b, ok);
      check({tag, "_frame"}, {31'd0, ok}, 32'd1);
      exp = (exp_q.size() > 0) ? {24'd0, exp_q.pop_front()} : 32'h100;
      check({tag, "_byte"}, {24'd0, b}, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    tx_valid = 1'b0;
    tx_data = 8'h00;

    // Reset held for 10 cycles
    for (int i = 0; i < 10; i++) begin
      tick();
      check("rst_tx", {31'd0, tx}, 32'd1);
      check("rst_ready", {31'd0, tx_ready}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_count", {27'd0, fifo_count}, 32'd0);
    end
    rst = 1'b0;
    tick();
    check("rel_ready", {31'd0, tx_ready}, 32'd1);
    check("rel_tx", {31'd0, tx}, 32'd1);
    repeat (3) tick();

    // Single byte 0x55: start bit after edge N+2, busy low after N+102
    push_byte(8'h55);
    check("single_count", {27'd0, fifo_count}, 32'd1);
    check("single_busy0", {31'd0, busy}, 32'd0);
    for (int k = 1; k <= 104; k++) begin
      tick();
      check("single_tx", {31'd0, tx}, {31'd0, (k >= 2 && k < 102) ? frame_bit(8'h55, k - 2) : 1'b1});
      check("single_busy", {31'd0, busy}, {31'd0, (k < 102) ? 1'b1 : 1'b0});
    end
    exp_q.delete();

    // Back-to-back 0xA3 then 0x0F: 200 contiguous line cycles
    push_byte(8'hA3);
    push_byte(8'h0F);
    for (int k = 2; k <= 204; k++) begin
      tick();
      check("b2b_tx", {31'd0, tx}, {31'd0, (k < 202) ? frame_bit((k < 102) ? 8'hA3 : 8'h0F, (k - 2) % 100) : 1'b1});
      check("b2b_busy", {31'd0, busy}, {31'd0, (k < 202) ? 1'b1 : 1'b0});
    end
    exp_q.delete();

    // Overflow: 18 pushes on consecutive cycles, only 17 accepted
    fork
      recv_and_score("ovf", 17);
      begin
        tx_valid = 1'b1;
        for (int i = 0; i < 18; i++) begin
          tx_data = 8'(i + 8'h30);
          check("ovf_ready", {31'd0, tx_ready}, {31'd0, (i < 17) ? 1'b1 : 1'b0});
          if (tx_ready === 1'b1) exp_q.push_back(8'(i + 8'h30));
          tick();
        end
        tx_valid = 1'b0;
        check("ovf_full_count", {27'd0, fifo_count}, 32'd16);
        repeat (83) tick();
        check("ovf_ready_low", {31'd0, tx_ready}, 32'd0);
        tick();
        check("ovf_ready_back", {31'd0, tx_ready}, 32'd1);
      end
    join
    check("ovf_q_empty", exp_q.size(), 32'd0);
    repeat (20) tick();
    check("ovf_idle_busy", {31'd0, busy}, 32'd0);

    // Reset during DATA bit 3 of 0xFF with three bytes queued
    push_byte(8'hFF);
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    repeat (41) tick();
    check("mid_pre_count", {27'd0, fifo_count}, 32'd3);
    check("mid_pre_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_tx", {31'd0, tx}, 32'd1);
    check("mid_rst_count", {27'd0, fifo_count}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_ready", {31'd0, tx_ready}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("mid_rel_ready", {31'd0, tx_ready}, 32'd1);
    exp_q.delete();
    for (int k = 0; k < 200; k++) begin
      tick();
      check("mid_quiet_tx", {31'd0, tx}, 32'd1);
      check("mid_quiet_busy", {31'd0, busy}, 32'd0);
    end

    // Loopback of all 256 byte values through the line decoder
    fork
      recv_and_score("loop", 256);
      for (int i = 0; i < 256; i++) push_byte(8'(i));
    join
    check("loop_q_empty", exp_q.size(), 32'd0);
    repeat (20) tick();
    check("end_busy", {31'd0, busy}, 32'd0);
    check("end_tx", {31'd0, tx}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
